// File: rtl/cmt_prog_ctrl.sv
// cmt_prog_ctrl
// Run-time frequency change sequencer for the programmable clock
// (DCM_CLKGEN followed by a fixed PLL). A request (M, D) is range-checked
// against the allowed DCM output window. An accepted request is shifted onto
// PROGEN/PROGDATA as LoadD, LoadM, GO. The controller then waits for progdone,
// pulses the PLL reset, and holds the output clock gated until the PLL has
// had time to relock.
//
// Ports
//   CLK           clock, also drives progclk of the clock block
//   rst_n         asynchronous active-low reset
//   req_valid     program request strobe, taken only while req_ready=1
//   req_ready     high only in IDLE
//   req_m, req_d  requested multiplier (2..256) and divider (1..256)
//   progen        DCM PROGEN
//   progdata      DCM PROGDATA
//   progdone_inv  from the clock block, low = programming finished
//   pll_reset     PLL reset
//   clk_ce        output clock enable
//   done          1-cycle pulse: new frequency active
//   err_range     1-cycle pulse: request rejected
//   err_timeout   1-cycle pulse: progdone never seen
//
// States
//   state       | meaning
//   S_IDLE      | ready for a request, outputs quiescent
//   S_LOAD_D    | shifting 1,0 then D-1 (LSB first) with progen=1
//   S_GAP1      | single idle cycle between loads
//   S_LOAD_M    | shifting 1,1 then M-1 (LSB first) with progen=1
//   S_GAP2      | single idle cycle before GO
//   S_GO        | GO command, progen=1 and progdata=0
//   S_WAIT_DONE | waiting for progdone_inv low (masked, then timed out)
//   S_PLL_RST   | pll_reset held high
//   S_LOCK_WAIT | waiting for the PLL to lock, clk_ce still gated

module cmt_prog_ctrl #(
   parameter int FREQ_IN          = 48,
   parameter int FMIN             = 21,
   parameter int FMAX             = 56,
   parameter int DONE_MASK        = 4,
   parameter int TIMEOUT_CYCLES   = 4096,
   parameter int PLL_RST_CYCLES   = 8,
   parameter int LOCK_WAIT_CYCLES = 2048
) (
   input  logic       CLK,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [8:0] req_m,
   input  logic [8:0] req_d,
   output logic       progen,
   output logic       progdata,
   input  logic       progdone_inv,
   output logic       pll_reset,
   output logic       clk_ce,
   output logic       done,
   output logic       err_range,
   output logic       err_timeout
);

   localparam int CNT_MAX_A = (TIMEOUT_CYCLES > LOCK_WAIT_CYCLES) ? TIMEOUT_CYCLES : LOCK_WAIT_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > PLL_RST_CYCLES) ? CNT_MAX_A : PLL_RST_CYCLES;
   localparam int CNT_W     = $clog2(CNT_MAX + 16);

   // WAIT_DONE cycle k holds cnt = TIMEOUT_CYCLES - k, so "past the mask"
   // (k > DONE_MASK) is cnt < TIMEOUT_CYCLES - DONE_MASK.
   localparam int MASK_LIM_I = (DONE_MASK < TIMEOUT_CYCLES) ? (TIMEOUT_CYCLES - DONE_MASK) : 0;

   localparam logic [CNT_W-1:0] CNT_SER   = CNT_W'(9);
   localparam logic [CNT_W-1:0] CNT_TO    = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_LOCK  = CNT_W'(LOCK_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] MASK_LIM  = CNT_W'(MASK_LIM_I);
   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD_D,
      S_GAP1,
      S_LOAD_M,
      S_GAP2,
      S_GO,
      S_WAIT_DONE,
      S_PLL_RST,
      S_LOCK_WAIT
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [8:0]       shreg;
   logic [7:0]       m_m1;

   logic [17:0] prod_in;
   logic [17:0] prod_max;
   logic [17:0] prod_min;
   logic        req_ok;

   // Unsigned 18-bit products: FREQ_IN*M must fall in [FMIN*D, FMAX*D].
   always_comb begin
      prod_in  = 18'(FREQ_IN) * {9'd0, req_m};
      prod_max = 18'(FMAX)    * {9'd0, req_d};
      prod_min = 18'(FMIN)    * {9'd0, req_d};
      req_ok   = (req_m >= 9'd2) && (req_m <= 9'd256) &&
                 (req_d >= 9'd1) && (req_d <= 9'd256) &&
                 (prod_in <= prod_max) && (prod_in >= prod_min);
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= CNT_ZERO;
         shreg       <= '0;
         m_m1        <= '0;
         req_ready   <= 1'b1;
         progen      <= 1'b0;
         progdata    <= 1'b0;
         pll_reset   <= 1'b0;
         clk_ce      <= 1'b1;
         done        <= 1'b0;
         err_range   <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         done        <= 1'b0;
         err_range   <= 1'b0;
         err_timeout <= 1'b0;

         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  if (req_ok) begin
                     state     <= S_LOAD_D;
                     req_ready <= 1'b0;
                     clk_ce    <= 1'b0;
                     progen    <= 1'b1;
                     progdata  <= 1'b1;
                     // first preamble bit goes out now; the rest is 0 then D-1
                     shreg     <= {8'(req_d - 9'd1), 1'b0};
                     m_m1      <= 8'(req_m - 9'd1);
                     cnt       <= CNT_SER;
                  end else begin
                     err_range <= 1'b1;
                  end
               end
            end

            S_LOAD_D: begin
               if (cnt == CNT_ZERO) begin
                  state    <= S_GAP1;
                  progen   <= 1'b0;
                  progdata <= 1'b0;
               end else begin
                  progdata <= shreg[0];
                  shreg    <= shreg >> 1;
                  cnt      <= cnt - CNT_ONE;
               end
            end

            S_GAP1: begin
               state    <= S_LOAD_M;
               progen   <= 1'b1;
               progdata <= 1'b1;
               shreg    <= {m_m1, 1'b1};
               cnt      <= CNT_SER;
            end

            S_LOAD_M: begin
               if (cnt == CNT_ZERO) begin
                  state    <= S_GAP2;
                  progen   <= 1'b0;
                  progdata <= 1'b0;
               end else begin
                  progdata <= shreg[0];
                  shreg    <= shreg >> 1;
                  cnt      <= cnt - CNT_ONE;
               end
            end

            S_GAP2: begin
               state    <= S_GO;
               progen   <= 1'b1;
               progdata <= 1'b0;
            end

            S_GO: begin
               state  <= S_WAIT_DONE;
               progen <= 1'b0;
               cnt    <= CNT_TO;
            end

            S_WAIT_DONE: begin
               // On the terminal cycle a low progdone beats the timeout even if still masked.
               if (!progdone_inv && ((cnt < MASK_LIM) || (cnt == CNT_ZERO))) begin
                  state     <= S_PLL_RST;
                  pll_reset <= 1'b1;
                  cnt       <= CNT_RST;
               end else if (cnt == CNT_ZERO) begin
                  state       <= S_IDLE;
                  req_ready   <= 1'b1;
                  err_timeout <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            S_PLL_RST: begin
               if (cnt == CNT_ZERO) begin
                  state     <= S_LOCK_WAIT;
                  pll_reset <= 1'b0;
                  cnt       <= CNT_LOCK;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            S_LOCK_WAIT: begin
               if (cnt == CNT_ZERO) begin
                  state     <= S_IDLE;
                  req_ready <= 1'b1;
                  clk_ce    <= 1'b1;
                  done      <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            default: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
               progen    <= 1'b0;
               progdata  <= 1'b0;
               pll_reset <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmt_prog_ctrl.sv
module tb_cmt_prog_ctrl;

   localparam int FREQ_IN   = 48;
   localparam int FMIN      = 21;
   localparam int FMAX      = 56;
   localparam int DONE_MASK = 4;
   localparam int TIMEOUT   = 4096;
   localparam int PLL_RST   = 8;
   localparam int LOCK_WAIT = 2048;

   logic       CLK = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [8:0] req_m;
   logic [8:0] req_d;
   logic       progen;
   logic       progdata;
   logic       progdone_inv;
   logic       pll_reset;
   logic       clk_ce;
   logic       done;
   logic       err_range;
   logic       err_timeout;

   int checks = 0;
   int passed = 0;
   bit model_ce = 1'b1;

   always #5 CLK = ~CLK;

   cmt_prog_ctrl dut (
      .CLK          (CLK),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_m        (req_m),
      .req_d        (req_d),
      .progen       (progen),
      .progdata     (progdata),
      .progdone_inv (progdone_inv),
      .pll_reset    (pll_reset),
      .clk_ce       (clk_ce),
      .done         (done),
      .err_range    (err_range),
      .err_timeout  (err_timeout)
   );

   function automatic bit ref_valid(input int m, input int d);
      return (m >= 2) && (m <= 256) && (d >= 1) && (d <= 256) &&
             (FREQ_IN * m <= FMAX * d) && (FREQ_IN * m >= FMIN * d);
   endfunction

   // Expected serial stream for cycle n after acceptance.
   function automatic void stream_exp(input int n, input int m, input int d,
                                      output bit pg, output bit pd, output bit use_pd);
      pg = 1'b0; pd = 1'b0; use_pd = 1'b1;
      if (n >= 1 && n <= 10) begin
         pg = 1'b1;
         if (n == 1)      pd = 1'b1;
         else if (n == 2) pd = 1'b0;
         else             pd = 1'(((d - 1) >> (n - 3)) & 1);
      end else if (n >= 12 && n <= 21) begin
         pg = 1'b1;
         if (n <= 13) pd = 1'b1;
         else         pd = 1'(((m - 1) >> (n - 14)) & 1);
      end else if (n == 23) begin
         pg = 1'b1;
      end else if (n != 11) begin
         use_pd = 1'b0;
      end
   endfunction

   task automatic chk(input string tag, input int n, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s c%0d: observed %b expected %b", tag, n, obs, exp);
   endtask

   task automatic check_all(input int n, input bit e_ready, input bit e_pg, input bit e_pd,
                            input bit use_pd, input bit e_pll, input bit e_ce, input bit e_done,
                            input bit e_er, input bit e_to);
      chk("req_ready", n, req_ready, e_ready);
      chk("progen", n, progen, e_pg);
      if (use_pd) chk("progdata", n, progdata, e_pd);
      chk("pll_reset", n, pll_reset, e_pll);
      chk("clk_ce", n, clk_ce, e_ce);
      chk("done", n, done, e_done);
      chk("err_range", n, err_range, e_er);
      chk("err_timeout", n, err_timeout, e_to);
   endtask

   // lo_from: first cycle whose end samples progdone_inv=0 (<=0 means low before the request).
   // abort_at: pull rst_n low after checking that cycle (0 = run to completion).
   task automatic run_req(input int m, input int d, input int lo_from, input int abort_at, input bit noise);
      bit v;
      int hit;
      int end_c;
      int last;
      int c_lo;
      bit e_pg, e_pd, use_pd;
      v     = ref_valid(m, d);
      hit   = -1;
      end_c = 1;
      if (v) begin
         c_lo = (lo_from > 24 + DONE_MASK) ? lo_from : 24 + DONE_MASK;
         if (c_lo <= 23 + TIMEOUT) hit = c_lo;
         end_c = (hit > 0) ? hit + 1 + PLL_RST + LOCK_WAIT : 24 + TIMEOUT;
      end
      last = (abort_at > 0) ? abort_at : end_c + 1;

      @(negedge CLK);
      req_valid    = 1'b1;
      req_m        = 9'(m);
      req_d        = 9'(d);
      progdone_inv = (lo_from <= 0) ? 1'b0 : 1'b1;

      for (int n = 1; n <= last; n++) begin
         @(negedge CLK);
         if (!v) begin
            check_all(n, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, model_ce, 1'b0, n == 1, 1'b0);
         end else begin
            stream_exp(n, m, d, e_pg, e_pd, use_pd);
            check_all(n, n >= end_c, e_pg, e_pd, use_pd,
                      (hit > 0) && (n > hit) && (n <= hit + PLL_RST),
                      (hit > 0) && (n >= end_c),
                      (hit > 0) && (n == end_c),
                      1'b0,
                      (hit < 0) && (n == end_c));
         end
         req_valid = (noise && n < end_c) ? 1'($urandom_range(0, 1)) : 1'b0;
         req_m     = 9'($urandom_range(0, 511));
         req_d     = 9'($urandom_range(0, 511));
         progdone_inv = (n >= lo_from) ? 1'b0 : 1'b1;
      end
      req_valid = 1'b0;

      if (abort_at > 0) begin
         rst_n = 1'b0;
         #1;
         chk("rst progen", abort_at, progen, 1'b0);
         chk("rst clk_ce", abort_at, clk_ce, 1'b1);
         chk("rst req_ready", abort_at, req_ready, 1'b1);
         chk("rst pll_reset", abort_at, pll_reset, 1'b0);
         @(negedge CLK);
         rst_n = 1'b1;
         model_ce = 1'b1;
      end else if (v) begin
         model_ce = (hit > 0);
      end
   endtask

   int bnd_m [8] = '{256, 257, 1, 2, 7, 7, 7, 7};
   int bnd_d [8] = '{256, 256, 1, 0, 6, 5, 16, 17};

   initial begin
      int m, d;
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_m        = '0;
      req_d        = '0;
      progdone_inv = 1'b1;
      repeat (3) @(negedge CLK);
      check_all(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      @(negedge CLK);
      check_all(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // 35.6 MHz, progdone 30 cycles after GO, stray requests during the sequence
      run_req(20, 27, 53, 0, 1'b1);
      run_req(2, 1, 1000000, 0, 1'b0);
      run_req(20, 50, 1000000, 0, 1'b0);
      // accepted but progdone never arrives: timeout leaves clk_ce gated
      run_req(38, 42, 1000000, 0, 1'b1);
      run_req(2, 1, 1000000, 0, 1'b0);

      for (int i = 0; i < 8; i++)
         run_req(bnd_m[i], bnd_d[i], 1000000, ref_valid(bnd_m[i], bnd_d[i]) ? 24 : 0, 1'b0);

      // reset in the middle of LoadM, then a full replay with progdone held low
      run_req(20, 27, 1000000, 15, 1'b0);
      run_req(20, 27, 0, 0, 1'b0);

      for (int i = 0; i < 16; i++) begin
         m = int'($urandom_range(0, 300));
         d = int'($urandom_range(0, 300));
         run_req(m, d, 1000000, ref_valid(m, d) ? int'($urandom_range(2, 30)) : 0, 1'b0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
